note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Record/playback controller in front of the key-code-to-one-hot decoder that feeds MainSound and Piano_VGA.
//  Captures the 6-bit key stream as (code, duration) events in an on-chip buffer.
//  Replays the events by driving the same 6-bit code bus that the decoder consumes.
//  When not playing, it passes live keys through, so sound and display stay live.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  100         duration tick rate (10 ms resolution at the default)
//  DEPTH    64          event buffer entries
//  DUR_W    8           duration field width; maximum ticks per event = 2^DUR_W-1
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  teclas_in    in   6   live key code; 0 = no key, 1..32 = note
//  rec_start    in   1   one-cycle pulse; start recording
//  play_start   in   1   one-cycle pulse; start playback
//  stop         in   1   one-cycle pulse; abort record or play
//  teclas_out   out  6   key code to the decoder (registered)
//  recording    out  1   high in the REC state
//  playing      out  1   high in the PLAY_FETCH and PLAY_HOLD states
//  full         out  1   buffer filled during the last recording
//  event_count  out  $clog2(DEPTH)+1   number of valid events stored
// BEHAVIOUR
//  Reset: teclas_out=0, recording=0, playing=0, full=0, event_count=0, state=IDLE, tick counter=0. Buffer RAM is not cleared.
//  Tick: a free-running divider emits a 1-cycle tick every CLK_HZ/TICK_HZ clocks. It is not realigned on start.
//  Sanitize: code = (teclas_in<=32) ? teclas_in : 0. Codes 33..63 are treated as a rest.
//  Command priority: stop > rec_start > play_start. Starts are accepted only in IDLE; otherwise they are ignored.
//  IDLE: teclas_out <= code, with 1-cycle latency.
//  IDLE --rec_start--> REC: event_count<=0, full<=0, cur<=code, dur<=0.
//  REC: teclas_out <= code (pass-through). On each tick:
//   - if code==cur and dur<MAX: dur<=dur+1;
//   - else: write (cur,dur) if dur!=0; then cur<=code, dur<=1.
//   - A write stores at address event_count, and event_count increments in the same cycle.
//  REC stop: flush (cur,dur) if dur!=0, in the cycle stop is seen. Then go to IDLE.
//  REC full: when a write makes event_count==DEPTH, go to IDLE and set full<=1. No further writes occur; a pending event is discarded.
//  IDLE --play_start, event_count!=0--> PLAY_FETCH with idx=0. If event_count==0, play_start is ignored.
//  PLAY_FETCH: synchronous RAM read of idx (1 cycle). Then teclas_out<=code[idx], remain<=dur[idx], go to PLAY_HOLD.
//  PLAY_HOLD: on each tick remain<=remain-1. On the tick where remain==1:
//   - idx+1==event_count: go to IDLE.
//   - else: idx<=idx+1, go to PLAY_FETCH.
//   - teclas_out holds the previous code during the fetch; no zero glitch between events.
//  End of playback: on return to IDLE, teclas_out follows live keys from the next cycle.
//  PLAY stop: go to IDLE. teclas_out<=code the next cycle.
//  During play: teclas_in is ignored. Buffer contents and event_count are preserved, so replay is repeatable.
//  Simultaneous tick and stop: stop wins; any flush uses dur before the tick update.
//  reset mid-operation: immediate return to the reset values; event_count=0 (recording lost).
// TESTING
//  (bench params: CLK_HZ=1000, TICK_HZ=100 -> tick every 10 clocks)
//  1 Reset with teclas_in=9 -> teclas_out=0, all flags 0, event_count=0; teclas_out=9 one cycle after reset release.
//  2 IDLE, teclas_in=5 -> teclas_out=5 next clock; teclas_in=40 -> teclas_out=0.
//  3 rec_start; hold 3 for 4 ticks, 7 for 2 ticks; stop -> event_count=2, RAM=(3,4),(7,2), recording=0.
//  4 After 3: play_start -> playing=1; teclas_out=3 for 4 ticks, then 7 for 2 ticks, then live keys; playing=0.
//  5 DUR_W=3: record code 1 held 10 ticks, stop -> events (1,7),(1,3); playback holds 1 for 10 ticks, with no 0 between.
//  6 DEPTH=4: change key every tick -> after 4th write recording=0, full=1, event_count=4.
//    play_start then stop at tick 2 -> teclas_out=live code next cycle.
//    rec_start then immediate stop -> event_count=0, and a following play_start is ignored.

Source files
------------

// File: rtl/note_sequencer.sv
// Record/playback sequencer for the 6-bit key-code bus: captures (code, duration) events into an
// on-chip buffer and replays them; passes live keys through whenever it is not playing.
module note_sequencer #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 100,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned DUR_W   = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [5:0]               teclas_in,
   input  logic                     rec_start,
   input  logic                     play_start,
   input  logic                     stop,
   output logic [5:0]               teclas_out,
   output logic                     recording,
   output logic                     playing,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   event_count
);

   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW      = $clog2(DEPTH) + 1;
   localparam int unsigned ENTRY_W = 6 + DUR_W;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;

   typedef enum logic [1:0] {StIdle, StRec, StPlayFetch, StPlayHold} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [5:0]         out_q, out_d;
   logic [CW-1:0]      count_q, count_d;
   logic               full_q, full_d;
   logic [5:0]         cur_q, cur_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [DUR_W-1:0]   remain_q, remain_d;

   logic               tick;
   logic [5:0]         code;
   logic               wr_en;
   logic               last_slot;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rd_data;

   assign tick      = (div_q == DIV_W'(DIV - 1));
   assign div_d     = tick ? '0 : div_q + DIV_W'(1);
   assign code      = (teclas_in <= 6'd32) ? teclas_in : 6'd0;
   assign last_slot = (count_q == CW'(DEPTH - 1));

   // Read address is the next index so the entry is ready during the single fetch cycle.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[count_q[AW-1:0]] <= {cur_q, dur_q};
      end
      rd_data <= mem[idx_d];
   end

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      count_d  = count_q;
      full_d   = full_q;
      cur_d    = cur_q;
      dur_d    = dur_q;
      idx_d    = idx_q;
      remain_d = remain_q;
      wr_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            out_d = code;
            if (stop) begin
               state_d = StIdle;
            end else if (rec_start) begin
               state_d = StRec;
               count_d = '0;
               full_d  = 1'b0;
               cur_d   = code;
               dur_d   = '0;
            end else if (play_start && (count_q != '0)) begin
               state_d = StPlayFetch;
               idx_d   = '0;
            end
         end
         StRec: begin
            out_d = code;
            if (stop) begin
               if (dur_q != '0) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
                  if (last_slot) full_d = 1'b1;
               end
               state_d = StIdle;
            end else if (tick) begin
               if ((code == cur_q) && (dur_q != DUR_MAX)) begin
                  dur_d = dur_q + DUR_W'(1);
               end else begin
                  cur_d = code;
                  dur_d = DUR_W'(1);
                  if (dur_q != '0) begin
                     wr_en   = 1'b1;
                     count_d = count_q + CW'(1);
                     if (last_slot) begin
                        full_d  = 1'b1;
                        state_d = StIdle;
                     end
                  end
               end
            end
         end
         StPlayFetch: begin
            if (stop) begin
               state_d = StIdle;
            end else begin
               out_d    = rd_data[ENTRY_W-1:DUR_W];
               remain_d = rd_data[DUR_W-1:0];
               state_d  = StPlayHold;
            end
         end
         StPlayHold: begin
            if (stop) begin
               state_d = StIdle;
            end else if (tick) begin
               remain_d = remain_q - DUR_W'(1);
               if (remain_q == DUR_W'(1)) begin
                  if ((CW'(idx_q) + CW'(1)) == count_q) begin
                     state_d = StIdle;
                  end else begin
                     idx_d   = idx_q + AW'(1);
                     state_d = StPlayFetch;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         div_q    <= '0;
         out_q    <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         cur_q    <= '0;
         dur_q    <= '0;
         idx_q    <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         out_q    <= out_d;
         count_q  <= count_d;
         full_q   <= full_d;
         cur_q    <= cur_d;
         dur_q    <= dur_d;
         idx_q    <= idx_d;
         remain_q <= remain_d;
      end
   end

   assign teclas_out  = out_q;
   assign recording   = (state_q == StRec);
   assign playing     = (state_q == StPlayFetch) || (state_q == StPlayHold);
   assign full        = full_q;
   assign event_count = count_q;

endmodule
